// File: rtl/alu_cmd_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer_pkg
// Description : Shared definitions for the ALU command issuer: opcode
//               encodings of the attached 4-bit ALU, the issuer FSM state
//               type, the queued-command record and the default FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_cmd_issuer_pkg;

    localparam int DEPTH_DEFAULT = 4;

    // Opcodes understood by the 4-bit ALU
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous FIFO for queued ALU commands. Power-of-two depth
//               so the read/write pointers wrap naturally.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   pop        : discard head entry (ignored when empty)
//   pop_data   : current head entry (combinational)
//   full/empty : occupancy flags, count : occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Queues ALU commands, drives them one at a time onto an
//               external combinational 4-bit ALU, captures the result and
//               flags and presents them on a valid/ready response port.
//   cmd_*      : command input handshake, operands and opcode
//   alu_*      : registered drive to the ALU / ALU return path
//   rsp_*      : registered response held until accepted
//   busy       : FSM active or commands queued, cmd_count : FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [2:0]             cmd_sel,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_sel,
    input  logic [3:0]             alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_overflow,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_overflow,
    output logic                   rsp_zero,
    output logic [2:0]             rsp_sel,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cmd_count
);

    state_t state;
    state_t next_state;

    cmd_t   push_cmd;
    cmd_t   head_cmd;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    logic   load_alu;
    logic   capture;
    logic   clear_rsp;

    assign push_cmd  = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    // full is derived purely from the occupancy count inside the FIFO
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Pop decisions use the pre-edge empty flag, so a command pushed on the
    // same edge is only seen (and popped) one edge later.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load_alu   = 1'b0;
        capture    = 1'b0;
        clear_rsp  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_alu   = 1'b1;
                    next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                capture    = 1'b1;
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_valid && rsp_ready) begin
                    clear_rsp = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_alu   = 1'b1;
                        next_state = ST_DRIVE;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_sel      <= '0;
        end else begin
            if (load_alu) begin
                alu_a   <= head_cmd.a;
                alu_b   <= head_cmd.b;
                alu_sel <= head_cmd.sel;
            end
            // Flags are taken raw from the ALU regardless of opcode.
            if (capture) begin
                rsp_valid    <= 1'b1;
                rsp_result   <= alu_result;
                rsp_carry    <= alu_carry;
                rsp_overflow <= alu_overflow;
                rsp_zero     <= alu_zero;
                rsp_sel      <= alu_sel;
            end else if (clear_rsp) begin
                rsp_valid    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-005 SHALL have ports: cmd_a input 4, cmd_b input 4, cmd_sel input 3  operands and opcode.
REQ-006 SHALL have ports: alu_a output 4, alu_b output 4, alu_sel output 3  drive to the combinational 4-bit ALU.
REQ-007 SHALL have ports: alu_result input 4, alu_carry input 1, alu_overflow input 1, alu_zero input 1  ALU return.
REQ-008 SHALL have ports: rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-009 SHALL have ports: rsp_result output 4, rsp_carry, rsp_overflow, rsp_zero output 1 each, rsp_sel output 3  captured response.
REQ-010 SHALL have ports: busy output 1 (state != IDLE or FIFO non-empty); cmd_count output clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-011 SHALL accept a command on any rising edge with cmd_valid && cmd_ready; cmd_ready = (cmd_count != DEPTH), combinational from count only.
REQ-012 SHALL store accepted commands in FIFO order; wrap-around of read/write pointers at DEPTH without loss.
REQ-013 SHALL implement FSM states IDLE, DRIVE, HOLD.
REQ-014 IDLE: if FIFO non-empty at edge, pop head into alu_a/alu_b/alu_sel registers, go DRIVE; else stay.
REQ-015 DRIVE: at next edge, register alu_result/carry/overflow/zero and alu_sel into rsp_* , set rsp_valid, go HOLD.
REQ-016 HOLD: rsp_* and alu_* held stable; on rsp_valid && rsp_ready edge clear rsp_valid, then pop next command and go DRIVE if FIFO non-empty, else go IDLE.
REQ-017 Latency: command accepted into empty FIFO at edge N with FSM IDLE -> alu_* updated after N+1 -> rsp_valid high after N+2.
REQ-018 Throughput with rsp_ready held high: one response per 2 cycles.
REQ-019 Simultaneous push and pop: count unchanged; push into full FIFO impossible (cmd_ready low); pop from empty never occurs (pop condition uses pre-edge count).
REQ-020 Push while FIFO empty and FSM IDLE: entry not popped in same edge; popped next edge.
REQ-021 Flags SHALL be captured raw for every opcode; no filtering by sel.
REQ-022 rsp_valid SHALL never drop without handshake; rsp_* SHALL not change while rsp_valid high.

Reset
REQ-023 rst high SHALL immediately clear: FSM to IDLE, FIFO pointers and cmd_count to 0, rsp_valid 0, rsp_* 0, alu_a/alu_b/alu_sel 0, busy 0.
REQ-024 Reset mid-operation SHALL discard queued commands and any pending response; no response emitted after deassertion until a new command is accepted.
REQ-025 cmd_ready SHALL be 1 during and after reset (count 0).

Structure
REQ-026 Shared package SHALL hold opcode constants (ADD 000, SUB 001, NOT 010, AND 011, OR 100, XOR 101, LT 110, EQ 111), FSM state enum, DEPTH default.
REQ-027 FIFO SHALL be a separate sub-module alu_cmd_fifo (push/pop/full/empty/count); FSM and capture registers in alu_cmd_issuer.
REQ-028 Bench SHALL connect the existing 4-bit ALU as the alu_* responder.

Verification
REQ-029 ADD A=7,B=1 -> rsp_result 1000, carry 0, overflow 1, zero 0, rsp_valid 2 cycles after accept.
REQ-030 SUB A=3,B=3 -> rsp_result 0000, carry 1, overflow 0, zero 1.
REQ-031 LT A=2,B=5 -> rsp_result 0001, rsp_sel 110; then EQ A=B=9 -> rsp_result 0001.
REQ-032 Push 5 commands back-to-back with rsp_ready 0 -> cmd_ready low once cmd_count 4 (one already in HOLD), all 5 responses later returned in order.
REQ-033 rsp_ready held 1, 8 queued commands -> responses every 2 cycles, pointer wrap verified, order preserved.
REQ-034 Assert rst in HOLD with 3 queued -> rsp_valid 0 and cmd_count 0 immediately; no stale response after release.
